// File: rtl/issue_pkg.sv
// Opcode constants and RV32 field/class decode helpers shared by the issue
// queue and its pairwise dependency checker.
package issue_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic logic [6:0] get_opcode(input logic [31:0] ins);
        return ins[6:0];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] ins);
        return ins[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [31:0] ins);
        return ins[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] ins);
        return ins[24:20];
    endfunction

    function automatic logic writes_rd(input logic [31:0] ins);
        return (get_opcode(ins) != OP_STORE) && (get_opcode(ins) != OP_BRANCH);
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ins);
        return (get_opcode(ins) != OP_LUI) && (get_opcode(ins) != OP_AUIPC) &&
               (get_opcode(ins) != OP_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        return (get_opcode(ins) == OP_REG) || (get_opcode(ins) == OP_STORE) ||
               (get_opcode(ins) == OP_BRANCH);
    endfunction

    function automatic logic is_mem(input logic [31:0] ins);
        return (get_opcode(ins) == OP_LOAD) || (get_opcode(ins) == OP_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [31:0] ins);
        return (get_opcode(ins) == OP_BRANCH) || (get_opcode(ins) == OP_JAL) ||
               (get_opcode(ins) == OP_JALR);
    endfunction

endpackage

// File: rtl/issue_dep_check.sv
// Pairwise issue hazard between an older and a younger instruction that would
// otherwise dual-issue in the same cycle.
module issue_dep_check
    import issue_pkg::*;
(
    input  logic [31:0] older_ins,
    input  logic [31:0] younger_ins,
    output logic        hazard
);

    logic rd_live_s;
    logic raw_s;
    logic waw_s;
    logic struct_s;

    assign rd_live_s = writes_rd(older_ins) && (get_rd(older_ins) != 5'd0);
    assign raw_s     = rd_live_s &&
                       ((reads_rs1(younger_ins) && (get_rs1(younger_ins) == get_rd(older_ins))) ||
                        (reads_rs2(younger_ins) && (get_rs2(younger_ins) == get_rd(older_ins))));
    assign waw_s     = rd_live_s && writes_rd(younger_ins) &&
                       (get_rd(younger_ins) == get_rd(older_ins));
    // One memory port, and nothing may issue alongside (after) a control transfer.
    assign struct_s  = (is_mem(older_ins) && is_mem(younger_ins)) || is_ctrl(older_ins);

    assign hazard = raw_s || waw_s || struct_s;

endmodule

// File: rtl/multi_issue_buffer.sv
// Circular instruction queue: accepts fetch groups at the tail and issues an
// in-order, hazard-free prefix of up to LANES entries from the head each cycle.
module multi_issue_buffer
    import issue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       fetch_valid,
    input  logic [$clog2(LANES+1)-1:0] fetch_count,
    input  logic [LANES*XLEN-1:0]      fetch_ins,
    output logic                       fetch_ready,
    input  logic                       stall,
    output logic [LANES-1:0]           issue_valid,
    output logic [LANES*XLEN-1:0]      issue_ins,
    output logic [LANES-1:0]           freeze,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int FCW = $clog2(LANES+1);

    logic [XLEN-1:0]        mem_q [DEPTH];
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          push_n_s;
    logic [CW-1:0]          pop_raw_s;
    logic [CW-1:0]          pop_n_s;
    logic                   push_ok_s;
    logic [LANES*LANES-1:0] hazard_s;

    assign count       = count_q;
    assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(LANES);

    // Issue window: the LANES entries starting at head, wrapping around.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            issue_ins[k*XLEN +: XLEN] = mem_q[head_q + PW'(k)];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_young
        for (genvar j = 0; j < LANES; j++) begin : g_old
            if (j < k) begin : g_chk
                issue_dep_check u_dep (
                    .older_ins   (issue_ins[j*XLEN +: 32]),
                    .younger_ins (issue_ins[k*XLEN +: 32]),
                    .hazard      (hazard_s[k*LANES+j])
                );
            end else begin : g_none
                assign hazard_s[k*LANES+j] = 1'b0;
            end
        end
    end

    // Lane k issues only if every older lane issues and none conflicts with it.
    always_comb begin
        issue_valid    = '0;
        freeze         = '0;
        pop_raw_s      = '0;
        issue_valid[0] = (count_q != '0);
        for (int k = 1; k < LANES; k++) begin
            issue_valid[k] = issue_valid[k-1] && (count_q > CW'(k)) &&
                             !(|hazard_s[k*LANES +: LANES]);
        end
        for (int k = 0; k < LANES; k++) begin
            freeze[k] = (count_q > CW'(k)) && (!issue_valid[k] || stall);
            pop_raw_s = pop_raw_s + CW'(issue_valid[k]);
        end
        if (stall || flush) begin
            pop_n_s = '0;
        end else begin
            pop_n_s = pop_raw_s;
        end
    end

    // Push size and next pointer/occupancy state.
    always_comb begin
        push_ok_s = fetch_valid && fetch_ready && !flush;
        if (!push_ok_s) begin
            push_n_s = '0;
        end else if (fetch_count > FCW'(LANES)) begin
            push_n_s = CW'(LANES);
        end else begin
            push_n_s = CW'(fetch_count);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_n_s);
            tail_d  = tail_q + PW'(push_n_s);
            count_d = count_q + push_n_s - pop_n_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (CW'(k) < push_n_s) begin
                mem_q[tail_q + PW'(k)] <= fetch_ins[k*XLEN +: XLEN];
            end
        end
    end

endmodule
